apb_timer_slave: RTL and testbench

- APB3 peripheral sitting directly downstream of the AHB-to-APB bridge; consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA/PREADY/PSLVERR.
- Provides a 32-bit down-counting timer with reload, an interrupt status register and an interrupt output.
- Programmable wait states make it the bench target for exercising the bridge's PREADY/PSLVERR paths.

---
 rtl/apb_timer_slave_if.sv | 24 ++
 rtl/apb_timer_slave.sv | 197 +++++++++++++++++++
 tb/tb_apb_timer_slave.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_slave_if.sv
// APB3 bus bundle between the bridge (master) and the timer peripheral (slave).
interface apb_timer_slave_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [DATAWIDTH-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_slave.sv
// APB3 timer peripheral: 32-bit down-counter with reload, sticky interrupt
// status and a level interrupt, plus programmable access-phase wait states.
// Optional feature macro: TIMER_PRESCALE_EN adds an 8-bit PRESCALE register at
// offset 0x10 that divides the timer tick; without it 0x10 is unmapped.
//
// APB FSM
//   state     | meaning
//   ST_IDLE   | no transfer in flight; watching for a setup phase
//   ST_SETUP  | setup phase seen last cycle; this is the first access cycle
//   ST_ACCESS | further access cycles while wait states run out
module apb_timer_slave #(
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_timer_slave_if.slave apb,
    output logic             TIMERINT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST    = 4'(WAIT_STATES);
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_VALUE    = 3'd1;
    localparam logic [2:0] OFF_RELOAD   = 3'd2;
    localparam logic [2:0] OFF_INTSTAT  = 3'd3;
`ifdef TIMER_PRESCALE_EN
    localparam logic [2:0] OFF_PRESCALE = 3'd4;
`endif

    state_t               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic [2:0]           offset;
    logic                 mapped;
    logic                 addr_err;
    logic                 access;
    logic                 pready;
    logic                 wr_ok;
    logic                 tick;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [DATAWIDTH-1:0] value_q, value_d;
    logic [DATAWIDTH-1:0] reload_q, reload_d;
    logic                 int_q, int_d;
    logic [DATAWIDTH-1:0] rdata;
`ifdef TIMER_PRESCALE_EN
    logic [7:0]           prescale_q, prescale_d;
    logic [7:0]           pcnt_q, pcnt_d;
`endif

    // Address bits above [4:0] are deliberately not decoded.
    logic unused_addr;
    assign unused_addr = ^apb.PADDR[ADDRWIDTH-1:5];

    assign offset = apb.PADDR[4:2];

    // Decode the word offset and flag unmapped or misaligned accesses.
    always_comb begin
        mapped = 1'b0;
        case (offset)
            OFF_CTRL, OFF_VALUE, OFF_RELOAD, OFF_INTSTAT: mapped = 1'b1;
`ifdef TIMER_PRESCALE_EN
            OFF_PRESCALE: mapped = 1'b1;
`endif
            default: mapped = 1'b0;
        endcase
        addr_err = !mapped || (apb.PADDR[1:0] != 2'b00);
    end

    assign access = (state_q != ST_IDLE) && apb.PSEL && apb.PENABLE;
    assign pready = access && (wait_q == WAIT_LAST);
    assign wr_ok  = pready && apb.PWRITE && !addr_err;

    // Bus phase tracking and wait-state counting.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                wait_d = 4'd0;
                if (apb.PSEL && !apb.PENABLE) state_d = ST_SETUP;
            end
            ST_SETUP, ST_ACCESS: begin
                if (!apb.PSEL || pready) begin
                    // A following back-to-back setup phase is picked up from IDLE.
                    state_d = ST_IDLE;
                    wait_d  = 4'd0;
                end else begin
                    state_d = ST_ACCESS;
                    if (wait_q < WAIT_LAST) wait_d = wait_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = 4'd0;
            end
        endcase
    end

    // FSM and wait counter registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Timer next state: tick handling first, then bus writes (written VALUE
    // wins over a tick), then interrupt set (set wins over W1C).
    always_comb begin
        ctrl_d   = ctrl_q;
        value_d  = value_q;
        reload_d = reload_q;
        int_d    = int_q;
`ifdef TIMER_PRESCALE_EN
        prescale_d = prescale_q;
        tick       = ctrl_q[0] && (pcnt_q == prescale_q);
        pcnt_d     = (!ctrl_q[0] || tick) ? 8'd0 : pcnt_q + 8'd1;
`else
        tick       = ctrl_q[0];
`endif
        if (tick) begin
            if (value_q > DATAWIDTH'(1))
                value_d = value_q - DATAWIDTH'(1);
            else if (value_q == DATAWIDTH'(1))
                value_d = ctrl_q[2] ? reload_q : '0;
        end
        if (wr_ok) begin
            case (offset)
                OFF_CTRL:    ctrl_d   = apb.PWDATA[2:0];
                OFF_VALUE:   value_d  = apb.PWDATA;
                OFF_RELOAD:  reload_d = apb.PWDATA;
                OFF_INTSTAT: if (apb.PWDATA[0]) int_d = 1'b0;
`ifdef TIMER_PRESCALE_EN
                OFF_PRESCALE: begin
                    prescale_d = apb.PWDATA[7:0];
                    pcnt_d     = 8'd0;
                end
`endif
                default: ;
            endcase
        end
        if (tick && (value_q == DATAWIDTH'(1))) int_d = 1'b1;
    end

    // Timer and configuration registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q   <= 3'd0;
            value_q  <= '0;
            reload_q <= '0;
            int_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            prescale_q <= 8'd0;
            pcnt_q     <= 8'd0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            value_q  <= value_d;
            reload_q <= reload_d;
            int_q    <= int_d;
`ifdef TIMER_PRESCALE_EN
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
`endif
        end
    end

    // Read data mux.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL:    rdata = {{(DATAWIDTH-3){1'b0}}, ctrl_q};
            OFF_VALUE:   rdata = value_q;
            OFF_RELOAD:  rdata = reload_q;
            OFF_INTSTAT: rdata = {{(DATAWIDTH-1){1'b0}}, int_q};
`ifdef TIMER_PRESCALE_EN
            OFF_PRESCALE: rdata = {{(DATAWIDTH-8){1'b0}}, prescale_q};
`endif
            default:     rdata = '0;
        endcase
    end

    assign apb.PRDATA  = (access && !apb.PWRITE && !addr_err) ? rdata : '0;
    assign apb.PREADY  = pready;
    assign apb.PSLVERR = pready && addr_err;
    assign TIMERINT    = int_q & ctrl_q[1];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: APB driver, bus monitor with a scoreboard queue,
// and a cycle-level reference model of the timer registers.
module tb_apb_timer_slave;

    localparam int WS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic timerint;

    always #5 clk = ~clk;

    apb_timer_slave_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) apb ();

    apb_timer_slave #(
        .ADDRWIDTH  (16),
        .DATAWIDTH  (32),
        .WAIT_STATES(WS)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .apb     (apb),
        .TIMERINT(timerint)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        string       tag;
        logic        wr;
        logic        err;
        logic [2:0]  off;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [2:0]  m_ctrl;
    logic [31:0] m_value, m_reload;
    logic        m_int;
    logic        mt_tick, mt_set, mt_ni;
    logic [31:0] mt_nv;
`ifdef TIMER_PRESCALE_EN
    logic [7:0]  m_pre, m_pcnt;
`endif

    // Commit requests from the monitor, consumed by the model on the next edge
    logic        c_we;
    logic [2:0]  c_off;
    logic [31:0] c_data;
    int          n_done = 0;
    int          mon_wait = 0;

    function automatic logic exp_err(input logic [15:0] a);
        if (a[1:0] != 2'b00) return 1'b1;
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: return 1'b0;
`ifdef TIMER_PRESCALE_EN
            3'd4: return 1'b0;
`endif
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return m_value;
            3'd2: return m_reload;
            3'd3: return {31'd0, m_int};
`ifdef TIMER_PRESCALE_EN
            3'd4: return {24'd0, m_pre};
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Timer reference model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = 3'd0; m_value = 32'd0; m_reload = 32'd0; m_int = 1'b0;
`ifdef TIMER_PRESCALE_EN
            m_pre = 8'd0; m_pcnt = 8'd0;
`endif
        end else begin
`ifdef TIMER_PRESCALE_EN
            mt_tick = m_ctrl[0] && (m_pcnt == m_pre);
            if (!m_ctrl[0] || mt_tick) m_pcnt = 8'd0; else m_pcnt = m_pcnt + 8'd1;
`else
            mt_tick = m_ctrl[0];
`endif
            mt_nv  = m_value;
            mt_ni  = m_int;
            mt_set = 1'b0;
            if (mt_tick) begin
                if (m_value > 32'd1) mt_nv = m_value - 32'd1;
                else if (m_value == 32'd1) begin
                    mt_nv  = m_ctrl[2] ? m_reload : 32'd0;
                    mt_set = 1'b1;
                end
            end
            if (c_we) begin
                case (c_off)
                    3'd0: m_ctrl   = c_data[2:0];
                    3'd1: mt_nv    = c_data;
                    3'd2: m_reload = c_data;
                    3'd3: if (c_data[0]) mt_ni = 1'b0;
`ifdef TIMER_PRESCALE_EN
                    3'd4: begin m_pre = c_data[7:0]; m_pcnt = 8'd0; end
`endif
                    default: ;
                endcase
            end
            if (mt_set) mt_ni = 1'b1;
            m_value = mt_nv;
            m_int   = mt_ni;
        end
    end

    // Bus monitor: checks idle outputs and interrupt every cycle, scoreboards completions
    always @(negedge clk) begin
        exp_t e;
        c_we = 1'b0;
        if (!rst_n) begin
            mon_wait = 0;
        end else begin
            chk("timerint", {31'd0, timerint}, {31'd0, m_int & m_ctrl[1]});
            if (apb.PSEL && apb.PENABLE) begin
                if (!apb.PREADY) begin
                    mon_wait++;
                end else begin
                    chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk({e.tag, "_waits"}, mon_wait, e.waits);
                        chk({e.tag, "_pslverr"}, {31'd0, apb.PSLVERR}, {31'd0, e.err});
                        chk({e.tag, "_prdata"}, apb.PRDATA, (e.wr || e.err) ? 32'd0 : m_read(e.off));
                        if (e.wr && !e.err) begin
                            c_we = 1'b1; c_off = e.off; c_data = e.data;
                        end
                    end
                    mon_wait = 0;
                    n_done++;
                end
            end else begin
                chk("pready_idle", {31'd0, apb.PREADY}, 32'd0);
                chk("pslverr_idle", {31'd0, apb.PSLVERR}, 32'd0);
                chk("prdata_idle", apb.PRDATA, 32'd0);
            end
        end
    end

    // One APB transfer; starts and ends just after a rising edge.
    task automatic apb_xfer(input string tag, input logic [15:0] addr, input logic wr,
                            input logic [31:0] data, input logic b2b);
        exp_t e;
        int   start;
        int   n;
        e.tag = tag; e.wr = wr; e.err = exp_err(addr); e.off = addr[4:2];
        e.data = data; e.waits = WS;
        sb.push_back(e);
        start = n_done;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = addr;
        apb.PWRITE = wr; apb.PWDATA = data;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        n = 0;
        while (n_done == start && n < WS + 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done"}, {31'd0, n_done != start}, 32'd1);
        if (!b2b) begin
            apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = '0;
        apb.PWRITE = 1'b0; apb.PWDATA = '0;
        rst_n = 1'b0;
        idle(2);
        chk("rst_pready", {31'd0, apb.PREADY}, 32'd0);
        chk("rst_pslverr", {31'd0, apb.PSLVERR}, 32'd0);
        chk("rst_prdata", apb.PRDATA, 32'd0);
        chk("rst_timerint", {31'd0, timerint}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Reset values over the bus
        for (int i = 0; i < 4; i++) apb_xfer("rst_rd", 16'(i * 4), 1'b0, 32'd0, 1'b0);

        // Autoreload countdown with interrupt
        apb_xfer("t1_reload", 16'h0008, 1'b1, 32'd5, 1'b1);
        apb_xfer("t1_value",  16'h0004, 1'b1, 32'd3, 1'b1);
        apb_xfer("t1_ctrl",   16'h0000, 1'b1, 32'h7, 1'b1);
        for (int i = 0; i < 4; i++) apb_xfer("t1_rdval", 16'h0004, 1'b0, 32'd0, 1'b1);
        apb_xfer("t1_rdint",  16'h000C, 1'b0, 32'd0, 1'b1);
        apb_xfer("t1_rdctrl", 16'h0000, 1'b0, 32'd0, 1'b0);
        apb_xfer("t1_stop",   16'h0000, 1'b1, 32'h0, 1'b0);
        apb_xfer("t1_w1c",    16'h000C, 1'b1, 32'h1, 1'b0);
        apb_xfer("t1_rdint2", 16'h000C, 1'b0, 32'd0, 1'b0);

        // One-shot: counts to zero and holds
        apb_xfer("t2_value", 16'h0004, 1'b1, 32'd2, 1'b0);
        apb_xfer("t2_ctrl",  16'h0000, 1'b1, 32'h3, 1'b0);
        for (int i = 0; i < 3; i++) apb_xfer("t2_rdval", 16'h0004, 1'b0, 32'd0, 1'b0);
        apb_xfer("t2_rdint", 16'h000C, 1'b0, 32'd0, 1'b0);
        apb_xfer("t2_w1c",   16'h000C, 1'b1, 32'h1, 1'b0);
        idle(3);
        apb_xfer("t2_rdint2", 16'h000C, 1'b0, 32'd0, 1'b0);
        apb_xfer("t2_rdval2", 16'h0004, 1'b0, 32'd0, 1'b0);

        // Wait states with back-to-back reads
        apb_xfer("t3_rdreload", 16'h0008, 1'b0, 32'd0, 1'b1);
        apb_xfer("t3_rdvalue",  16'h0004, 1'b0, 32'd0, 1'b0);

        // Error responses; registers stay untouched
        apb_xfer("t4_rd14",  16'h0014, 1'b0, 32'd0, 1'b0);
        apb_xfer("t4_wr06",  16'h0006, 1'b1, 32'hDEAD_BEEF, 1'b0);
        apb_xfer("t4_rd10",  16'h0010, 1'b0, 32'd0, 1'b0);
        apb_xfer("t4_wr1c",  16'h001C, 1'b1, 32'h7, 1'b0);
        apb_xfer("t4_rdval", 16'h0004, 1'b0, 32'd0, 1'b0);
        apb_xfer("t4_rdctl", 16'hFF00, 1'b0, 32'd0, 1'b0);

        // W1C landing on the same edge as the 1->reload event: set wins
        apb_xfer("t5_stop",   16'h0000, 1'b1, 32'h0, 1'b0);
        apb_xfer("t5_clr",    16'h000C, 1'b1, 32'h1, 1'b0);
        apb_xfer("t5_reload", 16'h0008, 1'b1, 32'd5, 1'b0);
        apb_xfer("t5_value",  16'h0004, 1'b1, 32'd4, 1'b0);
        apb_xfer("t5_ctrl",   16'h0000, 1'b1, 32'h7, 1'b1);
        apb_xfer("t5_w1c",    16'h000C, 1'b1, 32'h1, 1'b1);
        apb_xfer("t5_rdint",  16'h000C, 1'b0, 32'd0, 1'b0);
        // VALUE write while ticking
        apb_xfer("t5_wr9",    16'h0004, 1'b1, 32'd9, 1'b1);
        apb_xfer("t5_rd9",    16'h0004, 1'b0, 32'd0, 1'b0);

        // Reset in the completing access cycle of a pending write
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 16'h0004;
        apb.PWRITE = 1'b1; apb.PWDATA = 32'h77;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        idle(WS);
        chk("t6_pready_pre", {31'd0, apb.PREADY}, 32'd1);
        chk("t6_timerint_pre", {31'd0, timerint}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pready_rst", {31'd0, apb.PREADY}, 32'd0);
        chk("t6_prdata_rst", apb.PRDATA, 32'd0);
        chk("t6_timerint_rst", {31'd0, timerint}, 32'd0);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) apb_xfer("t6_rd", 16'(i * 4), 1'b0, 32'd0, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
